// File: rtl/cpu_ctrl_pkg.sv
// Shared types and field-slicing helpers for the CPU control sequencer.
// Holds the state and opcode enums, default widths, and constant functions
// that locate the opcode / A / B fields inside an instruction word.
package cpu_ctrl_pkg;

    localparam int unsigned DEF_OP_W    = 2;
    localparam int unsigned DEF_REG_AW  = 3;
    localparam int unsigned DEF_INSTR_W = DEF_OP_W + 2 * DEF_REG_AW;
    localparam int unsigned DEF_PC_W    = 8;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_READ   = 4'd3,
        ST_EXEC   = 4'd4,
        ST_WAIT   = 4'd5,
        ST_WB     = 4'd6,
        ST_WB2    = 4'd7,
        ST_NEXT   = 4'd8,
        ST_HALT   = 4'd9
    } state_e;

    typedef enum logic [1:0] {
        OP_ONE  = 2'd0,
        OP_ADD  = 2'd1,
        OP_SUB  = 2'd2,
        OP_SWAP = 2'd3
    } op_e;

    // MSB of the opcode field (top of the word)
    function automatic int unsigned op_msb(input int unsigned instr_w);
        return instr_w - 1;
    endfunction

    // MSB of register field A (sits directly above field B)
    function automatic int unsigned field_a_msb(input int unsigned reg_aw);
        return 2 * reg_aw - 1;
    endfunction

    // MSB of register field B (bottom of the word)
    function automatic int unsigned field_b_msb(input int unsigned reg_aw);
        return reg_aw - 1;
    endfunction

endpackage

// File: rtl/instr_decode.sv
// Combinational instruction field extraction and HALT detection.
// Ports:
//   instr_i   - latched instruction word
//   op_o      - opcode field
//   ra_o      - register field A
//   rb_o      - register field B
//   is_halt_o - word equals the HALT encoding (overrides the opcode)
module instr_decode
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned          INSTR_W    = DEF_INSTR_W,
    parameter int unsigned          OP_W       = DEF_OP_W,
    parameter int unsigned          REG_AW     = DEF_REG_AW,
    parameter logic [INSTR_W-1:0]   HALT_INSTR = {INSTR_W{1'b1}}
) (
    input  logic [INSTR_W-1:0] instr_i,
    output logic [OP_W-1:0]    op_o,
    output logic [REG_AW-1:0]  ra_o,
    output logic [REG_AW-1:0]  rb_o,
    output logic               is_halt_o
);

    localparam int unsigned OP_MSB = op_msb(INSTR_W);
    localparam int unsigned A_MSB  = field_a_msb(REG_AW);
    localparam int unsigned B_MSB  = field_b_msb(REG_AW);

    assign op_o      = instr_i[OP_MSB -: OP_W];
    assign ra_o      = instr_i[A_MSB -: REG_AW];
    assign rb_o      = instr_i[B_MSB -: REG_AW];
    assign is_halt_o = (instr_i == HALT_INSTR);

endmodule

// File: rtl/cpu_ctrl_seq.sv
// Fetch/decode/execute control sequencer.
// Ports:
//   clk, rst_n             - clock, async active-low reset
//   start                  - leaves IDLE when high (sampled only in IDLE)
//   imem_req/valid/data    - instruction fetch handshake, pc = fetch address
//   alu_op, ra_addr,
//   rb_addr                - registered decoded fields
//   rf_rd_en               - register read strobe
//   alu_start/done/zero    - ALU launch pulse and variable-latency completion
//   rf_wr_en/addr/sel      - register writeback (sel 1 = swap operand B)
//   flag_zero              - sticky zero flag
//   halted, state          - HALT indicator and debug state encoding
module cpu_ctrl_seq
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned        INSTR_W    = DEF_INSTR_W,
    parameter int unsigned        OP_W       = DEF_OP_W,
    parameter int unsigned        REG_AW     = DEF_REG_AW,
    parameter int unsigned        PC_W       = DEF_PC_W,
    parameter logic [INSTR_W-1:0] HALT_INSTR = {INSTR_W{1'b1}}
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               imem_req,
    input  logic               imem_valid,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [PC_W-1:0]    pc,
    output logic [OP_W-1:0]    alu_op,
    output logic [REG_AW-1:0]  ra_addr,
    output logic [REG_AW-1:0]  rb_addr,
    output logic               rf_rd_en,
    output logic               alu_start,
    input  logic               alu_done,
    input  logic               alu_zero,
    output logic               rf_wr_en,
    output logic [REG_AW-1:0]  rf_wr_addr,
    output logic               rf_wr_sel,
    output logic               flag_zero,
    output logic               halted,
    output logic [3:0]         state
);

    state_e              state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [INSTR_W-1:0]  instr_q, instr_d;
    logic [OP_W-1:0]     op_q, op_d;
    logic [REG_AW-1:0]   ra_q, ra_d;
    logic [REG_AW-1:0]   rb_q, rb_d;
    logic                flag_zero_q, flag_zero_d;

    logic [OP_W-1:0]     dec_op;
    logic [REG_AW-1:0]   dec_ra;
    logic [REG_AW-1:0]   dec_rb;
    logic                dec_halt;
    logic                is_swap;

    instr_decode #(
        .INSTR_W    (INSTR_W),
        .OP_W       (OP_W),
        .REG_AW     (REG_AW),
        .HALT_INSTR (HALT_INSTR)
    ) u_decode (
        .instr_i   (instr_q),
        .op_o      (dec_op),
        .ra_o      (dec_ra),
        .rb_o      (dec_rb),
        .is_halt_o (dec_halt)
    );

    assign is_swap = (op_q == OP_W'(OP_SWAP));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start) state_d = ST_FETCH;
            ST_FETCH:  if (imem_valid) state_d = ST_DECODE;
            ST_DECODE: state_d = dec_halt ? ST_HALT : ST_READ;
            ST_READ:   state_d = ST_EXEC;
            ST_EXEC:   state_d = ST_WAIT;
            ST_WAIT:   if (alu_done) state_d = ST_WB;
            ST_WB:     state_d = is_swap ? ST_WB2 : ST_NEXT;
            ST_WB2:    state_d = ST_NEXT;
            ST_NEXT:   state_d = ST_FETCH;
            ST_HALT:   state_d = ST_HALT;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Strobes decoded from the current state only (no input-to-output path)
    always_comb begin
        imem_req   = 1'b0;
        rf_rd_en   = 1'b0;
        alu_start  = 1'b0;
        rf_wr_en   = 1'b0;
        rf_wr_addr = '0;
        rf_wr_sel  = 1'b0;
        halted     = 1'b0;
        case (state_q)
            ST_FETCH: imem_req  = 1'b1;
            ST_READ:  rf_rd_en  = 1'b1;
            ST_EXEC:  alu_start = 1'b1;
            ST_WB: begin
                rf_wr_en   = 1'b1;
                rf_wr_addr = ra_q;
            end
            ST_WB2: begin
                rf_wr_en   = 1'b1;
                rf_wr_addr = rb_q;
                rf_wr_sel  = 1'b1;
            end
            ST_HALT:  halted    = 1'b1;
            default:  ;
        endcase
    end

    // Datapath next values: instruction latch, decoded fields, flag, pc
    always_comb begin
        pc_d        = pc_q;
        instr_d     = instr_q;
        op_d        = op_q;
        ra_d        = ra_q;
        rb_d        = rb_q;
        flag_zero_d = flag_zero_q;
        if (state_q == ST_FETCH && imem_valid) instr_d = imem_data;
        if (state_q == ST_DECODE && !dec_halt) begin
            op_d = dec_op;
            ra_d = dec_ra;
            rb_d = dec_rb;
        end
        // SWAP produces no arithmetic result, so the flag is left alone
        if (state_q == ST_WAIT && alu_done && !is_swap) flag_zero_d = alu_zero;
        if (state_q == ST_NEXT) pc_d = pc_q + PC_W'(1);
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q        <= '0;
            instr_q     <= '0;
            op_q        <= '0;
            ra_q        <= '0;
            rb_q        <= '0;
            flag_zero_q <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            op_q        <= op_d;
            ra_q        <= ra_d;
            rb_q        <= rb_d;
            flag_zero_q <= flag_zero_d;
        end
    end

    assign pc        = pc_q;
    assign alu_op    = op_q;
    assign ra_addr   = ra_q;
    assign rb_addr   = rb_q;
    assign flag_zero = flag_zero_q;
    assign state     = state_q;

endmodule

// File: tb/tb_cpu_ctrl_seq.sv
// Self-checking bench for cpu_ctrl_seq: a cycle-exact vector table built from
// a per-instruction timeline model (directed cases, then randomized program
// with don't-care inputs randomized), applied and compared once per cycle.
module tb_cpu_ctrl_seq;

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_FETCH  = 4'd1;
    localparam logic [3:0] S_DECODE = 4'd2;
    localparam logic [3:0] S_READ   = 4'd3;
    localparam logic [3:0] S_EXEC   = 4'd4;
    localparam logic [3:0] S_WAIT   = 4'd5;
    localparam logic [3:0] S_WB     = 4'd6;
    localparam logic [3:0] S_WB2    = 4'd7;
    localparam logic [3:0] S_NEXT   = 4'd8;
    localparam logic [3:0] S_HALT   = 4'd9;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       imem_valid = 1'b0;
    logic [7:0] imem_data = 8'h00;
    logic       alu_done = 1'b0;
    logic       alu_zero = 1'b0;

    logic       imem_req;
    logic [7:0] pc;
    logic [1:0] alu_op;
    logic [2:0] ra_addr, rb_addr;
    logic       rf_rd_en, alu_start, rf_wr_en, rf_wr_sel;
    logic [2:0] rf_wr_addr;
    logic       flag_zero, halted;
    logic [3:0] state;

    cpu_ctrl_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .imem_req   (imem_req),
        .imem_valid (imem_valid),
        .imem_data  (imem_data),
        .pc         (pc),
        .alu_op     (alu_op),
        .ra_addr    (ra_addr),
        .rb_addr    (rb_addr),
        .rf_rd_en   (rf_rd_en),
        .alu_start  (alu_start),
        .alu_done   (alu_done),
        .alu_zero   (alu_zero),
        .rf_wr_en   (rf_wr_en),
        .rf_wr_addr (rf_wr_addr),
        .rf_wr_sel  (rf_wr_sel),
        .flag_zero  (flag_zero),
        .halted     (halted),
        .state      (state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       req;
        logic [7:0] pc;
        logic [1:0] op;
        logic [2:0] ra;
        logic [2:0] rb;
        logic       rd;
        logic       ast;
        logic       wr;
        logic [2:0] waddr;
        logic       wsel;
        logic       fz;
        logic       halt;
        logic [3:0] st;
    } outs_t;

    typedef struct {
        logic       rst;
        logic       start;
        logic       ivalid;
        logic [7:0] idata;
        logic       adone;
        logic       azero;
        outs_t      exp;
    } vec_t;

    vec_t vec_q[$];

    // Architectural model state
    logic [7:0] m_pc;
    logic [1:0] m_op;
    logic [2:0] m_ra, m_rb;
    logic       m_fz;
    bit         noise;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic rnd();
        return noise ? 1'($urandom) : 1'b0;
    endfunction

    function automatic logic [7:0] rid();
        return noise ? 8'($urandom) : 8'h00;
    endfunction

    function automatic void push(input logic [3:0] st, input logic req, input logic rd,
                                 input logic ast, input logic wr, input logic [2:0] waddr,
                                 input logic wsel, input logic halt, input logic rst,
                                 input logic s, input logic iv, input logic [7:0] id,
                                 input logic ad, input logic az);
        vec_t v;
        v.rst    = rst;
        v.start  = s;
        v.ivalid = iv;
        v.idata  = id;
        v.adone  = ad;
        v.azero  = az;
        v.exp    = '{req, m_pc, m_op, m_ra, m_rb, rd, ast, wr, waddr, wsel, m_fz, halt, st};
        vec_q.push_back(v);
    endfunction

    function automatic void gen_idle(input logic s);
        push(S_IDLE, 0, 0, 0, 0, 3'd0, 0, 0, 0, s, rnd(), rid(), rnd(), rnd());
    endfunction

    function automatic void gen_reset();
        m_pc = 8'h00; m_op = 2'd0; m_ra = 3'd0; m_rb = 3'd0; m_fz = 1'b0;
        push(S_IDLE, 0, 0, 0, 0, 3'd0, 0, 0, 1, 0, rnd(), rid(), rnd(), rnd());
    endfunction

    // One instruction: fw extra fetch wait cycles, aw WAIT cycles (>=1).
    // abort>0 stops after that many WAIT cycles without alu_done.
    function automatic void gen_instr(input logic [7:0] ins, input int fw, input int aw,
                                      input logic az, input int abort);
        for (int i = 0; i <= fw; i++)
            push(S_FETCH, 1, 0, 0, 0, 3'd0, 0, 0, 0, rnd(), (i == fw),
                 (i == fw) ? ins : rid(), rnd(), rnd());
        push(S_DECODE, 0, 0, 0, 0, 3'd0, 0, 0, 0, rnd(), rnd(), rid(), rnd(), rnd());
        if (ins == 8'hFF) return;
        m_op = ins[7:6];
        m_ra = ins[5:3];
        m_rb = ins[2:0];
        push(S_READ, 0, 1, 0, 0, 3'd0, 0, 0, 0, rnd(), rnd(), rid(), rnd(), rnd());
        push(S_EXEC, 0, 0, 1, 0, 3'd0, 0, 0, 0, rnd(), rnd(), rid(), rnd(), rnd());
        if (abort > 0) begin
            for (int i = 0; i < abort; i++)
                push(S_WAIT, 0, 0, 0, 0, 3'd0, 0, 0, 0, rnd(), rnd(), rid(), 0, rnd());
            return;
        end
        for (int i = 1; i <= aw; i++)
            push(S_WAIT, 0, 0, 0, 0, 3'd0, 0, 0, 0, rnd(), rnd(), rid(),
                 (i == aw), (i == aw) ? az : rnd());
        if (m_op != 2'd3) m_fz = az;
        push(S_WB, 0, 0, 0, 1, m_ra, 0, 0, 0, rnd(), rnd(), rid(), rnd(), rnd());
        if (m_op == 2'd3)
            push(S_WB2, 0, 0, 0, 1, m_rb, 1, 0, 0, rnd(), rnd(), rid(), rnd(), rnd());
        push(S_NEXT, 0, 0, 0, 0, 3'd0, 0, 0, 0, rnd(), rnd(), rid(), rnd(), rnd());
        m_pc = m_pc + 8'd1;
    endfunction

    task automatic check(input int k, input outs_t e);
        outs_t a;
        a = '{imem_req, pc, alu_op, ra_addr, rb_addr, rf_rd_en, alu_start, rf_wr_en,
              rf_wr_addr, rf_wr_sel, flag_zero, halted, state};
        n_checks++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL vec%0d exp_state=%0d: got %h (st=%0d pc=%h wr=%b@%0d sel=%b fz=%b) required %h (st=%0d pc=%h wr=%b@%0d sel=%b fz=%b)",
                     k, e.st, a, a.st, a.pc, a.wr, a.waddr, a.wsel, a.fz,
                     e, e.st, e.pc, e.wr, e.waddr, e.wsel, e.fz);
        end
    endtask

    initial begin
        logic [7:0] ins;
        vec_t v;
        outs_t rst_exp;

        m_pc = 8'h00; m_op = 2'd0; m_ra = 3'd0; m_rb = 3'd0; m_fz = 1'b0;
        noise = 1'b0;

        // Directed program
        gen_idle(0);
        gen_idle(0);
        gen_idle(1);
        gen_instr(8'h4A, 0, 1, 1'b0, 0);   // ADD A=1 B=2, 7-cycle loop
        gen_instr(8'h9B, 0, 5, 1'b1, 0);   // SUB, ALU latency 5, zero set
        gen_instr(8'hD1, 0, 1, 1'b0, 0);   // SWAP A=2 B=1, flag unchanged
        gen_instr(8'h08, 10, 1, 1'b0, 0);  // ONE with 10-cycle fetch stall
        gen_instr(8'hDB, 0, 2, 1'b1, 0);   // SWAP with A==B
        // Randomized program with noise on ignored inputs; crosses pc 0xFF
        noise = 1'b1;
        for (int n = 0; n < 300; n++) begin
            ins = 8'($urandom);
            if (ins == 8'hFF) ins = 8'hFE;
            if (m_pc == 8'hFF) ins = {2'b00, 6'($urandom)};
            gen_instr(ins, int'($urandom_range(0, 3)), int'($urandom_range(1, 4)),
                      1'($urandom), 0);
        end
        // Reset during WAIT of an ADD
        gen_instr(8'h4A, 0, 1, 1'b0, 2);
        gen_reset();
        // HALT, start pulses ignored
        gen_idle(1);
        gen_instr(8'hFF, 1, 1, 1'b0, 0);
        for (int i = 0; i < 8; i++)
            push(S_HALT, 0, 0, 0, 0, 3'd0, 0, 1, 0, 1'(i), rnd(), rid(), rnd(), rnd());
        gen_reset();
        gen_idle(0);
        gen_idle(1);
        gen_instr(8'h4A, 0, 1, 1'b0, 0);

        // Reset values while rst_n held low
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_exp = '{1'b0, 8'h00, 2'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, S_IDLE};
        check(-1, rst_exp);
        rst_n = 1'b1;

        for (int k = 0; k < vec_q.size(); k++) begin
            @(negedge clk);
            v = vec_q[k];
            start      = v.start;
            imem_valid = v.ivalid;
            imem_data  = v.idata;
            alu_done   = v.adone;
            alu_zero   = v.azero;
            if (v.rst) rst_n = 1'b0;
            #1;
            check(k, v.exp);
            if (v.rst) begin
                #1;
                rst_n = 1'b1;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
